urv_irq_ctrl: RTL and testbench

//  Interrupt controller in front of the uRV exception unit. Synchronises N_IRQ external

---
 rtl/urv_irq_ctrl.sv | 155 +++++++++++++++
 tb/tb_urv_irq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/urv_irq_ctrl.sv
// urv_irq_ctrl - interrupt controller in front of the uRV exception unit.
//
// Synchronises N_IRQ external sources and latches them as pending, either on
// a rising edge or while the source is high, selected per source. Pending
// sources are masked with ENABLE, and the lowest index wins by fixed priority.
// The winner is requested on irq_o. The controller then tracks one in-service
// interrupt, from ack (exception taken) until eoi (eret retired).
//
// Ports
//   clk_i         system clock
//   rst_n_i       synchronous active-low reset
//   irq_src_i     raw interrupt sources (may be asynchronous)
//   cfg_we_i      register write strobe
//   cfg_addr_i    register select: 0 ENABLE, 1 PENDING (W1C), 2 EDGE, 3 STATUS
//   cfg_wdata_i   register write data
//   cfg_rdata_o   register read data, combinational on cfg_addr_i
//   irq_o         interrupt request to the core
//   irq_ack_i     core took the interrupt
//   eoi_i         end of interrupt
//   irq_id_o      id of the requested / in-service source
//   irq_active_o  an interrupt is in service
module urv_irq_ctrl #(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_IRQ-1:0] irq_src_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o,
  output logic             irq_o,
  input  logic             irq_ack_i,
  input  logic             eoi_i,
  output logic [4:0]       irq_id_o,
  output logic             irq_active_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       id_q, id_d;
  logic [4:0]       winner;
  logic             winner_found;

  logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [N_IRQ-1:0] enable_q, edge_q, pending_q, pending_d;
  logic [N_IRQ-1:0] set_vec, w1c_vec, ack_clr, cand, id_onehot;
  logic             cand_any, cand_hit;

  // Bits of the write data beyond N_IRQ are ignored by every register.
  logic             unused_wdata;
  assign unused_wdata = &{1'b0, cfg_wdata_i};

  // Edge sources fire on a 0->1 transition of the synchronised signal. Level
  // sources fire on every cycle the synchronised signal is high.
  assign set_vec = (edge_q & s2_q & ~s3_q) | (~edge_q & s2_q);
  assign w1c_vec = (cfg_we_i && cfg_addr_i == 2'd1) ? cfg_wdata_i[N_IRQ-1:0] : '0;
  assign cand    = pending_q & enable_q;
  assign cand_any = |cand;

  // A one-hot form of id_q avoids indexing a narrow vector with a 5-bit id.
  always_comb begin
    id_onehot = '0;
    for (int unsigned i = 0; i < N_IRQ; i++)
      id_onehot[i] = (5'(i) == id_q);
  end
  assign cand_hit = |(cand & id_onehot);

  // Fixed priority: the lowest set index wins.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (cand[i] && !winner_found) begin
        winner       = 5'(i);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (cand_any) begin
          state_d = S_REQ;
          id_d    = winner;
        end
      end
      S_REQ: begin
        // ack beats withdrawal. The id stays frozen while the request is up.
        if (irq_ack_i) begin
          state_d = S_SERVICE;
          ack_clr = id_onehot & edge_q;
        end else if (!cand_hit) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new set event wins over a clear in the same cycle.
  assign pending_d = (pending_q & ~(w1c_vec | ack_clr)) | set_vec;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      id_q      <= '0;
      state_q   <= S_IDLE;
    end else begin
      s1_q      <= irq_src_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      id_q      <= id_d;
      state_q   <= state_d;
      if (cfg_we_i && cfg_addr_i == 2'd0)
        enable_q <= cfg_wdata_i[N_IRQ-1:0];
      if (cfg_we_i && cfg_addr_i == 2'd2)
        edge_q <= cfg_wdata_i[N_IRQ-1:0];
    end
  end

  assign irq_o        = (state_q == S_REQ);
  assign irq_active_o = (state_q == S_SERVICE);
  assign irq_id_o     = id_q;

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      2'd0:    cfg_rdata_o[N_IRQ-1:0] = enable_q;
      2'd1:    cfg_rdata_o[N_IRQ-1:0] = pending_q;
      2'd2:    cfg_rdata_o[N_IRQ-1:0] = edge_q;
      default: cfg_rdata_o[5:0]       = {irq_active_o, irq_id_o};
    endcase
  end

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Testbench for urv_irq_ctrl (N_IRQ = 8). Each expected request id is queued
// when its stimulus is driven. A monitor pops the queue on each rising edge
// of irq_o.
module tb_urv_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  src = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        irq;
  logic        ack = 1'b0;
  logic        eoi = 1'b0;
  logic [4:0]  irq_id;
  logic        active;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_q[$];
  logic        irq_prev = 1'b0;
  logic [31:0] rd;

  urv_irq_ctrl #(.N_IRQ(8)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .irq_src_i    (src),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_rdata_o  (cfg_rdata),
    .irq_o        (irq),
    .irq_ack_i    (ack),
    .eoi_i        (eoi),
    .irq_id_o     (irq_id),
    .irq_active_o (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard: each new request must carry the next queued id.
  always @(negedge clk) begin
    if (irq && !irq_prev) begin
      if (exp_q.size() == 0)
        check("sb_unexpected_irq", 32'(irq), 32'd0);
      else
        check("sb_irq_id", 32'(irq_id), 32'(exp_q.pop_front()));
    end
    irq_prev = irq;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src = '0; ack = 1'b0; eoi = 1'b0; cfg_we = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 20 && !irq; i++)
      tick();
    check(tag, 32'(irq), 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    // 1: single edge source, 3-clock pending latency, 1-clock request latency
    do_reset();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    read_reg(2'd3, rd); check("rst_status", rd, 32'h0);
    cfg_write(2'd0, 32'h01);
    cfg_write(2'd2, 32'h01);
    read_reg(2'd0, rd); check("t1_enable", rd, 32'h01);
    exp_q.push_back(0);
    src[0] = 1'b1; tick(); src[0] = 1'b0;
    tick();
    read_reg(2'd1, rd); check("t1_pend_early", rd, 32'h0);
    tick();
    read_reg(2'd1, rd); check("t1_pend", rd, 32'h01);
    check("t1_irq_early", 32'(irq), 32'd0);
    tick();
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_id", 32'(irq_id), 32'd0);
    pulse_ack();
    check("t1_active", 32'(active), 32'd1);
    check("t1_irq_off", 32'(irq), 32'd0);
    read_reg(2'd1, rd); check("t1_pend_clr", rd, 32'h0);
    read_reg(2'd3, rd); check("t1_status", rd, 32'h20);
    pulse_eoi();
    check("t1_eoi", 32'(active), 32'd0);

    // 2: priority, then re-request two cycles after eoi
    do_reset();
    cfg_write(2'd0, 32'hFF);
    cfg_write(2'd2, 32'hFF);
    exp_q.push_back(2); exp_q.push_back(5);
    src = 8'h24; tick(); src = '0;
    wait_irq("t2_req");
    check("t2_id", 32'(irq_id), 32'd2);
    pulse_ack();
    read_reg(2'd1, rd); check("t2_pend", rd, 32'h20);
    pulse_eoi();
    check("t2_idle_irq", 32'(irq), 32'd0);
    check("t2_idle_active", 32'(active), 32'd0);
    tick();
    check("t2_rereq", 32'(irq), 32'd1);
    check("t2_id5", 32'(irq_id), 32'd5);

    // 3: level source held high stays pending; set beats W1C
    do_reset();
    cfg_write(2'd0, 32'h08);
    exp_q.push_back(3); exp_q.push_back(3);
    src[3] = 1'b1;
    wait_irq("t3_req");
    pulse_ack();
    read_reg(2'd1, rd); check("t3_pend_ack", rd, 32'h08);
    pulse_eoi();
    check("t3_gap", 32'(irq), 32'd0);
    tick();
    check("t3_rereq", 32'(irq), 32'd1);
    cfg_write(2'd1, 32'h08);
    read_reg(2'd1, rd); check("t3_w1c", rd, 32'h08);
    src[3] = 1'b0;

    // 4: withdrawal by disabling, later ack ignored
    do_reset();
    cfg_write(2'd0, 32'h02);
    cfg_write(2'd2, 32'h02);
    exp_q.push_back(1);
    src[1] = 1'b1; tick(); src[1] = 1'b0;
    wait_irq("t4_req");
    check("t4_id", 32'(irq_id), 32'd1);
    cfg_write(2'd0, 32'h0);
    tick();
    check("t4_withdraw", 32'(irq), 32'd0);
    pulse_ack();
    check("t4_ack_ign", 32'(active), 32'd0);
    check("t4_irq_low", 32'(irq), 32'd0);

    // 5: reset during service clears everything
    do_reset();
    cfg_write(2'd0, 32'h01);
    cfg_write(2'd2, 32'h05);
    exp_q.push_back(0);
    src = 8'h05; tick(); src = '0;
    wait_irq("t5_req");
    pulse_ack();
    check("t5_active", 32'(active), 32'd1);
    read_reg(2'd1, rd); check("t5_pend_pre", rd, 32'h04);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t5_irq", 32'(irq), 32'd0);
    check("t5_act", 32'(active), 32'd0);
    check("t5_id", 32'(irq_id), 32'd0);
    read_reg(2'd3, rd); check("t5_status", rd, 32'h0);
    read_reg(2'd1, rd); check("t5_pend", rd, 32'h0);
    read_reg(2'd0, rd); check("t5_enable", rd, 32'h0);
    pulse_eoi();
    check("t5_eoi_ign", 32'(active), 32'd0);
    tick(3);
    check("t5_no_irq", 32'(irq), 32'd0);

    // 6: no nesting; a source arriving during service waits for eoi
    do_reset();
    cfg_write(2'd0, 32'h81);
    cfg_write(2'd2, 32'h81);
    exp_q.push_back(0); exp_q.push_back(7);
    src[0] = 1'b1; tick(); src[0] = 1'b0;
    wait_irq("t6_req");
    pulse_ack();
    src[7] = 1'b1; tick(); src[7] = 1'b0;
    tick(4);
    read_reg(2'd1, rd); check("t6_pend7", rd, 32'h80);
    check("t6_no_irq", 32'(irq), 32'd0);
    check("t6_active", 32'(active), 32'd1);
    pulse_eoi();
    check("t6_gap", 32'(irq), 32'd0);
    tick();
    check("t6_req7", 32'(irq), 32'd1);
    check("t6_id7", 32'(irq_id), 32'd7);

    do_reset();
    tick(2);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
